// File: rtl/apb_master_bridge.sv
// CPU-to-APB master bridge: one outstanding transfer, address decode across
// up to four slaves, and a bounded ACCESS phase that aborts on timeout.
//
//   state  | meaning
//   IDLE   | waiting for cpu_req; decode errors complete here without a bus cycle
//   SETUP  | PSEL asserted, PENABLE low, for one cycle
//   ACCESS | PSEL and PENABLE high until PREADY or timeout
module apb_master_bridge #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] APB_BASE   = 32'h0000_1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_done,
  output logic                    cpu_err,
  output logic                    cpu_busy,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLAVES-1:0]   PSEL,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]   PREADY,
  input  logic [NUM_SLAVES-1:0]   PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [2:0] NUM_SLAVES_W = 3'(NUM_SLAVES);
  localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  dec_idx;
  logic        dec_hit;
  logic        sel_ready;
  logic        sel_err;
  logic [31:0] sel_rdata;

  assign dec_idx = cpu_addr[9:8];
  assign dec_hit = (cpu_addr[31:10] == APB_BASE[31:10]) &&
                   ({1'b0, dec_idx} < NUM_SLAVES_W);

  // Only the latched slave's response is ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == i[1:0]) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (dec_hit) begin
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
            idx_d   = dec_idx;
            state_d = ST_SETUP;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = sel_err;
          rdata_d = we_q ? 32'd0 : sel_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // PSEL/PENABLE decode straight from registered state so reset drops them on the same edge.
  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = (state_q != ST_IDLE) && (idx_q == i[1:0]);
    end
  end

  assign PENABLE   = (state_q == ST_ACCESS);
  assign cpu_busy  = (state_q != ST_IDLE);
  assign PADDR     = addr_q;
  assign PWRITE    = we_q;
  assign PWDATA    = wdata_q;
  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reads, waited writes, decode and slave
// errors, timeout, mid-transfer reset and back-to-back transfers.
module tb_apb_master_bridge;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_done;
  logic         cpu_err;
  logic         cpu_busy;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic         PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic [3:0]   PSLVERR;
  logic [31:0]  prd [4];

  int n_chk  = 0;
  int n_pass = 0;

  assign PRDATA = {prd[3], prd[2], prd[1], prd[0]};

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .NUM_SLAVES(4),
    .APB_BASE  (32'h0000_1000),
    .TIMEOUT   (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_done (cpu_done),
    .cpu_err  (cpu_err),
    .cpu_busy (cpu_busy),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    int acc;
    int got;
    int t1;
    int t2;
    int ndone;

    PRESET    = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    PREADY    = '0;
    PSLVERR   = '0;
    prd[0] = 32'h1234_5678;
    prd[1] = 32'hCAFE_F00D;
    prd[2] = 32'h5555_AAAA;
    prd[3] = 32'h0BAD_BEEF;
    step();
    step();
    chk("rst_psel", {28'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    PRESET = 1'b0;
    step();

    // Read slave 1, zero waits; other slaves' error lines are noise.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1104;
    PREADY = 4'b0010; PSLVERR = 4'b1101;
    step();
    cpu_req = 1'b0;
    chk("rd_c1_psel", {28'd0, PSEL}, 32'h2);
    chk("rd_c1_penable", {31'd0, PENABLE}, 32'd0);
    chk("rd_c1_busy", {31'd0, cpu_busy}, 32'd1);
    step();
    chk("rd_c2_psel", {28'd0, PSEL}, 32'h2);
    chk("rd_c2_penable", {31'd0, PENABLE}, 32'd1);
    chk("rd_c2_done", {31'd0, cpu_done}, 32'd0);
    step();
    chk("rd_c3_done", {31'd0, cpu_done}, 32'd1);
    chk("rd_c3_rdata", cpu_rdata, 32'hCAFE_F00D);
    chk("rd_c3_err", {31'd0, cpu_err}, 32'd0);
    chk("rd_c3_psel", {28'd0, PSEL}, 32'd0);
    step();
    chk("rd_c4_done", {31'd0, cpu_done}, 32'd0);

    // Write slave 2, three wait states, cpu_* churn while busy.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1200; cpu_wdata = 32'h0000_00A5;
    PREADY = 4'b0001; PSLVERR = 4'b0000;
    step();
    cpu_addr = 32'h0000_2000; cpu_wdata = 32'hFFFF_FFFF; cpu_we = 1'b0;
    chk("wr_c1_psel", {28'd0, PSEL}, 32'h4);
    chk("wr_c1_penable", {31'd0, PENABLE}, 32'd0);
    chk("wr_c1_pwrite", {31'd0, PWRITE}, 32'd1);
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 5) begin
        PREADY  = 4'b0101;
        cpu_req = 1'b0;
      end
      chk($sformatf("wr_c%0d_penable", c), {31'd0, PENABLE}, 32'd1);
      chk($sformatf("wr_c%0d_paddr", c), PADDR, 32'h0000_1200);
      chk($sformatf("wr_c%0d_pwdata", c), PWDATA, 32'h0000_00A5);
      chk($sformatf("wr_c%0d_done", c), {31'd0, cpu_done}, 32'd0);
    end
    step();
    chk("wr_c6_done", {31'd0, cpu_done}, 32'd1);
    chk("wr_c6_err", {31'd0, cpu_err}, 32'd0);
    chk("wr_c6_rdata", cpu_rdata, 32'd0);
    chk("wr_c6_busy", {31'd0, cpu_busy}, 32'd0);

    // Decode error outside the window.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2000;
    PREADY = 4'b1111;
    step();
    cpu_req = 1'b0;
    chk("dec_psel", {28'd0, PSEL}, 32'd0);
    chk("dec_done", {31'd0, cpu_done}, 32'd1);
    chk("dec_err", {31'd0, cpu_err}, 32'd1);
    chk("dec_busy", {31'd0, cpu_busy}, 32'd0);
    step();
    chk("dec_done_drop", {31'd0, cpu_done}, 32'd0);

    // Slave error from slave 0 on a write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1000; cpu_wdata = 32'h1;
    PREADY = 4'b0001; PSLVERR = 4'b0001;
    step();
    cpu_req = 1'b0;
    chk("se_psel", {28'd0, PSEL}, 32'h1);
    step();
    step();
    chk("se_done", {31'd0, cpu_done}, 32'd1);
    chk("se_err", {31'd0, cpu_err}, 32'd1);
    PSLVERR = '0;
    step();

    // Timeout: slave 0 never ready; rdata must read back as zero.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1010;
    PREADY = 4'b1110;
    step();
    cpu_req = 1'b0;
    acc = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cpu_done) begin
        got = 1;
        break;
      end
      if (PENABLE) acc++;
    end
    chk("to_done", got, 1);
    chk("to_access_cycles", acc, 16);
    chk("to_err", {31'd0, cpu_err}, 32'd1);
    chk("to_rdata", cpu_rdata, 32'd0);
    step();
    chk("to_done_drop", {31'd0, cpu_done}, 32'd0);

    // Follow-up read from slave 3 after the timeout.
    cpu_req = 1'b1; cpu_addr = 32'h0000_1300;
    PREADY = 4'b1000;
    step();
    cpu_req = 1'b0;
    chk("post_psel", {28'd0, PSEL}, 32'h8);
    step();
    step();
    chk("post_done", {31'd0, cpu_done}, 32'd1);
    chk("post_err", {31'd0, cpu_err}, 32'd0);
    chk("post_rdata", cpu_rdata, 32'h0BAD_BEEF);
    step();

    // Reset pulsed during ACCESS.
    cpu_req = 1'b1; cpu_addr = 32'h0000_1104;
    PREADY = 4'b0000;
    step();
    cpu_req = 1'b0;
    step();
    chk("rst_mid_penable", {31'd0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    chk("rst_mid_psel", {28'd0, PSEL}, 32'd0);
    chk("rst_mid_penable0", {31'd0, PENABLE}, 32'd0);
    chk("rst_mid_paddr", PADDR, 32'd0);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    chk("rst_mid_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_mid_busy", {31'd0, cpu_busy}, 32'd0);
    PREADY = 4'b0010;
    step();
    chk("rst_mid_done2", {31'd0, cpu_done}, 32'd0);

    // Back-to-back reads with cpu_req held high.
    cpu_req = 1'b1; cpu_addr = 32'h0000_1104;
    t1 = 0;
    t2 = 0;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 6) cpu_req = 1'b0;
      if (cpu_done) begin
        ndone++;
        if (ndone == 1) t1 = c;
        if (ndone == 2) t2 = c;
      end
    end
    chk("b2b_count", ndone, 2);
    chk("b2b_first", t1, 3);
    chk("b2b_gap", t2 - t1, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
